// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state codes and the default baud divider,
// common to the receive and transmit sides of the host link.
package uart_rx_pkg;

  localparam int CLK_PER_BIT_DEF = 868;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: circular buffer, show-ahead read, pushes dropped when full
// (full is judged on the count before any same-cycle pop).
module uart_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// byte FIFO popped through a valid/ready interface.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_PER_BIT     = CLK_PER_BIT_DEF,
  parameter int FIFO_DEPTH_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [31:0] P    = 32'(CLK_PER_BIT + 1);
  localparam logic [31:0] HALF = P >> 1;

  logic        sync1_q, rxs_q;
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        push, frame_err_d, overrun_d;
  logic        frame_err_q, overrun_q;
  logic        fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          cnt_d   = HALF - 32'd1;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
            cnt_d   = P - 32'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = rxs_q;
          cnt_d          = P - 32'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        // Stop bit is judged at its midpoint so the next start edge is never missed.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (rxs_q) push        = 1'b1;
          else       frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase
  end

  assign overrun_d = push && fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (rx_ready),
    .data_o  (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal 8N1 line driver, reference model deciding each
// frame's fate, and a monitor popping an expected-byte scoreboard.
module tb_uart_rx;

  localparam int CPB   = 15;
  localparam int P     = CPB + 1;
  localparam int HALF  = P / 2;
  localparam int DLOG  = 2;
  localparam int DEPTH = 1 << DLOG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid, frame_err, overrun;

  int total = 0, bad = 0;
  int cyc = 0, last_fall = 0;
  int exp_ferr = 0, exp_ovr = 0, got_ferr = 0, got_ovr = 0;
  logic [7:0] expq[$];
  logic rnd_done = 1'b0;

  uart_rx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rdata(rdata), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulse cycles and checks every handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) got_ferr++;
      if (overrun)   got_ovr++;
      if (rx_valid && rx_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got byte 0x%0h with empty scoreboard", rdata);
        end else begin
          check("rdata", int'(rdata), int'(expq.pop_front()));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Called just after a rising edge; the model decides the byte's fate in the
  // stop-sample cycle (fall + 2 + HALF + 9*P) using the pre-pop occupancy.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    #1 rxd = 1'b0;
    last_fall = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (P) @(posedge clk);
      #1 rxd = b[i];
    end
    repeat (P) @(posedge clk);
    #1 rxd = stop_bit;
    repeat (2 + HALF) @(posedge clk);
    #1;
    if (!stop_bit)                 exp_ferr++;
    else if (expq.size() >= DEPTH) exp_ovr++;
    else                           expq.push_back(b);
    if (pop_at_stop) rx_ready = 1'b1;
    @(posedge clk);
    #1 if (pop_at_stop) rx_ready = 1'b0;
    repeat (P - HALF - 3) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    #1 rx_ready = 1'b1;
    while ((expq.size() != 0 || rx_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_rx_valid", int'(rx_valid), 0);
    check("drain_left", expq.size(), 0);
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_frame_err_cnt"}, got_ferr, exp_ferr);
    check({tag, "_overrun_cnt"}, got_ovr, exp_ovr);
  endtask

  initial begin
    int t_valid;
    logic [7:0] b;
    logic stp;
    int gap;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Single byte: rx_valid rises 2 + HALF + 9*P + 1 cycles after the falling edge
    t_valid = -1;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        for (int n = 0; n < 400 && t_valid < 0; n++) begin
          @(negedge clk);
          if (rx_valid) t_valid = cyc - last_fall;
        end
      end
    join
    check("single_latency", t_valid, 2 + HALF + 9 * P + 1);
    check("single_rdata_showahead", int'(rdata), 8'h55);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("single_valid_after_pop", int'(rx_valid), 0);
    check("single_left", expq.size(), 0);

    // Glitch shorter than half a bit
    idle(5);
    #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    idle(40);
    @(negedge clk);
    check("glitch_rx_valid", int'(rx_valid), 0);
    check_pulses("glitch");

    // Framing error, then a good byte
    @(posedge clk);
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(40);
    @(negedge clk);
    check("ferr_rx_valid", int'(rx_valid), 0);
    check_pulses("ferr");
    @(posedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);
    @(negedge clk);
    check("after_ferr_valid", int'(rx_valid), 1);
    drain();

    // Overrun: five bytes into a four-deep FIFO with no consumer
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      send_frame(8'(k), 1'b1, 1'b0);
    end
    idle(10);
    check_pulses("overrun");
    drain();

    // Full FIFO with a pop in the stop-sample cycle still drops the new byte
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      send_frame(8'h11 + 8'(k), 1'b1, 1'b0);
    end
    @(posedge clk);
    send_frame(8'h15, 1'b1, 1'b1);
    idle(10);
    check_pulses("full_pop");
    drain();

    // Back-to-back frames with a live consumer
    @(posedge clk);
    #1 rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("b2b_left", expq.size(), 0);
    check_pulses("b2b");
    #1 rx_ready = 1'b0;

    // Reset during bit 3 of 0x81 with one byte already queued
    @(posedge clk);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(5);
    #1 rxd = 1'b0;
    b = 8'h81;
    for (int i = 0; i < 3; i++) begin
      repeat (P) @(posedge clk);
      #1 rxd = b[i];
    end
    repeat (P + 5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd = 1'b1;
    expq.delete();
    @(negedge clk);
    check("rst_fifo_emptied", int'(rx_valid), 0);
    idle(40);
    @(negedge clk);
    check("rst_no_push", int'(rx_valid), 0);
    @(posedge clk);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(10);
    drain();
    check_pulses("rst");

    // Randomized frames, stop bits and consumer back-pressure
    fork
      begin
        stp = 1'b1;
        for (int f = 0; f < 40; f++) begin
          gap = $urandom_range(0, 12);
          if (!stp && gap < 3) gap = 3;
          idle(gap);
          b   = 8'($urandom);
          stp = ($urandom_range(0, 7) != 0);
          send_frame(b, stp, 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    idle(20);
    drain();
    check_pulses("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
